seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Time-shares the single seven-segment display path (digit sequencer → `seg7` decoder, `rollover` limit lookup) between up to `NUM_REQ` independent requesters. Each requester asks to show one name word; the arbiter grants round-robin, latches the requester's name, steps the digit index at a programmable dwell rate until the word's last digit has been shown, then pulses `done` and blanks for a fixed gap before serving the next requester. It sits between the requesters and the existing `seg7`/`rollover` instances and replaces the free-running digit counter.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DWELL_DEFAULT`, 24'd10_000_000: cycles per digit when `dwell` == 0
- `GAP_CYCLES`, 24'd1_000_000: blank cycles between words, ≥1

- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `req` in `NUM_REQ`: level request; held until own `done` pulse or abandoned
- `req_name` in 3×`NUM_REQ`: name select per requester, slice i = bits [3i+2:3i]
- `dwell` in 24: cycles per digit; 0 selects `DWELL_DEFAULT`
- `digit_limit` in 5: last digit index of `name`, from `rollover` (combinational on `name`)
- `grant` out `NUM_REQ`: one-hot owner, all-zero when nobody owns the display
- `done` out `NUM_REQ`: one-cycle pulse to owner when its word completes
- `name` out 3: latched name to `seg7`/`rollover`
- `digit` out 5: current digit index to `seg7`
- `blank` out 1: high when segments must be forced off (IDLE, GAP)
- `busy` out 1: high in SHOW or GAP

## Operation
- FSM states: IDLE, SHOW, GAP. Reset → IDLE; `grant`=0, `done`=0, `name`=0, `digit`=0, `blank`=1, `busy`=0, RR pointer=0, dwell counter=0.
- IDLE: if any `req` bit set, select winner by round-robin starting at pointer; register `grant`=one-hot(winner), `name`=`req_name[winner]`, `digit`=0, counter=0, dwell latched (0 → `DWELL_DEFAULT`); go SHOW. Pointer ← winner+1 mod `NUM_REQ`.
- SHOW: `blank`=0. Counter increments each cycle; at counter == latched dwell−1: counter ← 0; if `digit` == `digit_limit` → `done[owner]` pulses next cycle, `grant` ← 0, go GAP; else `digit` ← `digit`+1.
- Abort: owner's `req` low in SHOW → `grant` ← 0, no `done`, go GAP. Abort takes precedence over a simultaneous completion.
- GAP: `blank`=1, `grant`=0, counter counts `GAP_CYCLES` cycles, then IDLE. Requests are not sampled in GAP.
- `name`, latched dwell stable for whole SHOW; `req_name`/`dwell` changes mid-word ignored.
- Non-owner `req` changes never affect the current word.
- Counter 24-bit, unsigned, no saturation needed (compare caps it). `digit` 5-bit; `digit_limit` ≥ 31 cannot occur past 31 since compare terminates at equality.

## Timing
- `req` sampled high in IDLE at edge k → `grant`, `name`, `busy` valid after edge k (1-cycle latency).
- Each digit visible exactly D cycles (D = latched dwell); word of L+1 digits occupies (L+1)·D cycles of SHOW.
- `done` high exactly one cycle, coincident with first GAP cycle and `grant`=0.
- Earliest re-grant: `GAP_CYCLES`+1 cycles after `done`.
- `reset` mid-operation: next cycle all outputs at reset values; no `done` issued.

## Configuration
- `SEG_ARB_PRIORITY_EN` defined: requester 0 wins whenever its `req` is set in IDLE, regardless of pointer; pointer updates only on grants to requesters 1..`NUM_REQ`−1. No preemption of a running word.
- Undefined: pure round-robin over all requesters.

## Structure
- Shared package: state enum (IDLE/SHOW/GAP), `DWELL_W`=24, `DIGIT_W`=5, `NAME_W`=3 constants.
- One sub-module: `rr_pick` — combinational round-robin one-hot picker (req vector, pointer → one-hot, index). The FSM, counters and latches stay in the top.

## Test plan
- `NUM_REQ`=4, `dwell`=3, `GAP_CYCLES`=2, req=4'b0010, `req_name[1]`=3, `digit_limit`=2 → grant=0010 one cycle later; digit 0,1,2 each 3 cycles; `done`=0010 for one cycle; 2 blank cycles; idle.
- req=4'b1111 held, each drops after own `done` → grant order 0001,0010,0100,1000 (with macro: 0001 first; repeated req0 retaken after each word).
- Owner drops `req` at digit 1 → grant 0 next cycle, no `done`, `blank`=1 for `GAP_CYCLES`.
- `dwell`=0 → each digit lasts 10_000_000 cycles (check first transition only); `dwell`=1 → digit advances every cycle.
- `reset` asserted mid-SHOW at digit 2 → next cycle grant=0, digit=0, name=0, blank=1, busy=0, no `done`.
- Change `req_name[owner]` and `dwell` during SHOW → `name` and digit period unchanged until word end.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and widths for the seven-segment display arbiter.
package seg_display_arbiter_pkg;

    localparam int unsigned DWELL_W = 24;
    localparam int unsigned DIGIT_W = 5;
    localparam int unsigned NAME_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping modulo NUM_REQ) wins; returns it one-hot and as an index.
module seg_display_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               pick_valid
);

    int unsigned cand;

    // Scan requesters in priority order starting at the pointer.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(cand);
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares the seven-segment digit path between NUM_REQ requesters.
// Grants round-robin, shows the owner's name word digit by digit at the
// latched dwell rate, pulses done, then blanks for GAP_CYCLES.
// Optional build macro SEG_ARB_PRIORITY_EN: requester 0 always wins in IDLE
// and the round-robin pointer only moves on grants to other requesters.
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int unsigned         NUM_REQ       = 4,
    parameter logic [DWELL_W-1:0]  DWELL_DEFAULT = 24'd10_000_000,
    parameter logic [DWELL_W-1:0]  GAP_CYCLES    = 24'd1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NAME_W*NUM_REQ-1:0] req_name,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic [DIGIT_W-1:0]        digit_limit,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [NAME_W-1:0]         name,
    output logic [DIGIT_W-1:0]        digit,
    output logic                      blank,
    output logic                      busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] grant_n, done_n;
    logic [NAME_W-1:0]  name_n;
    logic [DIGIT_W-1:0] digit_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [PTR_W-1:0]   ptr, ptr_n;

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   win_idx;
    logic               win_valid;
    logic               ptr_adv;

    seg_display_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign blank = (state != ST_SHOW);
    assign busy  = (state != ST_IDLE);

    // Next-state, counter and latch logic for IDLE/SHOW/GAP.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        done_n     = '0;
        name_n     = name;
        digit_n    = digit;
        cnt_n      = cnt;
        dwell_n    = dwell_q;
        ptr_n      = ptr;
        win_onehot = pick;
        win_idx    = pick_idx;
        win_valid  = pick_valid;
        ptr_adv    = 1'b1;
`ifdef SEG_ARB_PRIORITY_EN
        if (req[0]) begin
            win_onehot = NUM_REQ'(1);
            win_idx    = '0;
            win_valid  = 1'b1;
            ptr_adv    = 1'b0;
        end
`endif
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_n = win_onehot;
                    name_n  = req_name[win_idx*NAME_W +: NAME_W];
                    digit_n = '0;
                    cnt_n   = '0;
                    dwell_n = (dwell == '0) ? DWELL_DEFAULT : dwell;
                    state_n = ST_SHOW;
                    if (ptr_adv)
                        ptr_n = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            ST_SHOW: begin
                // Abort is checked first so it wins over a coincident completion.
                if ((req & grant) == '0) begin
                    grant_n = '0;
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end else if (cnt == dwell_q - DWELL_W'(1)) begin
                    cnt_n = '0;
                    if (digit == digit_limit) begin
                        done_n  = grant;
                        grant_n = '0;
                        state_n = ST_GAP;
                    end else begin
                        digit_n = digit + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_CYCLES - DWELL_W'(1)) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                grant_n = '0;
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            grant   <= '0;
            done    <= '0;
            name    <= '0;
            digit   <= '0;
            cnt     <= '0;
            dwell_q <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            done    <= done_n;
            name    <= name_n;
            digit   <= digit_n;
            cnt     <= cnt_n;
            dwell_q <= dwell_n;
            ptr     <= ptr_n;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed tables and sequences
// plus randomized traffic against a timeline-based reference model.
module tb_seg_display_arbiter;

    localparam int NR  = 4;
    localparam int DEF = 6;
    localparam int G   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] req_name;
    logic [23:0] dwell;
    logic [4:0]  digit_limit;
    logic [3:0]  grant, done;
    logic [2:0]  name;
    logic [4:0]  digit;
    logic        blank, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    seg_display_arbiter #(
        .NUM_REQ       (NR),
        .DWELL_DEFAULT (24'(DEF)),
        .GAP_CYCLES    (24'(G))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_name    (req_name),
        .dwell       (dwell),
        .digit_limit (digit_limit),
        .grant       (grant),
        .done        (done),
        .name        (name),
        .digit       (digit),
        .blank       (blank),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the rollover lookup: last digit index of each name word.
    function automatic int lim_of(input logic [2:0] n);
        case (n)
            3'd0: return 1;
            3'd1: return 3;
            3'd2: return 0;
            3'd3: return 2;
            3'd4: return 4;
            3'd5: return 1;
            3'd6: return 2;
            3'd7: return 3;
            default: return 0;
        endcase
    endfunction

    assign digit_limit = 5'(lim_of(name));

    // Reference model: mode 0 idle, 1 show, 2 gap; digit derived from elapsed time.
    int         m_mode = 0, m_ptr = 0, m_owner = 0, m_start = 0, m_gstart = 0, m_D = 1, m_digit = 0;
    logic [3:0] m_grant = '0, m_done = '0;
    logic [2:0] m_name = '0;

    task automatic model_edge();
        int win, el;
        m_done = '0;
        if (reset) begin
            m_mode = 0; m_grant = '0; m_name = '0; m_digit = 0; m_ptr = 0;
        end else if (m_mode == 0) begin
            win = -1;
`ifdef SEG_ARB_PRIORITY_EN
            if (req[0]) win = 0;
`endif
            for (int k = 0; k < NR; k++)
                if (win < 0 && req[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
            if (win >= 0) begin
`ifdef SEG_ARB_PRIORITY_EN
                if (!(req[0])) m_ptr = (win + 1) % NR;
`else
                m_ptr = (win + 1) % NR;
`endif
                m_owner = win;
                m_grant = 4'(1 << win);
                m_name  = req_name[3*win +: 3];
                m_D     = (dwell == 0) ? DEF : int'(dwell);
                m_start = cyc + 1;
                m_digit = 0;
                m_mode  = 1;
            end
        end else if (m_mode == 1) begin
            el = cyc - m_start + 1;
            if (!req[m_owner]) begin
                m_mode = 2; m_grant = '0; m_gstart = cyc + 1;
            end else if (el == (lim_of(m_name) + 1) * m_D) begin
                m_done = m_grant; m_mode = 2; m_grant = '0; m_gstart = cyc + 1;
            end else begin
                m_digit = el / m_D;
            end
        end else begin
            if (cyc + 1 - m_gstart == G) m_mode = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: advance the model on the current inputs, then compare after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("m_grant", 32'(grant), 32'(m_grant));
        chk("m_done",  32'(done),  32'(m_done));
        chk("m_blank", 32'(blank), 32'(m_mode != 1));
        chk("m_busy",  32'(busy),  32'(m_mode != 0));
        if (m_mode == 1) begin
            chk("m_name",  32'(name),  32'(m_name));
            chk("m_digit", 32'(digit), 32'(m_digit));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic [3:0] d;
        logic [4:0] dig;
        logic       bl;
        logic       bz;
    } vec_t;

    vec_t       tv[13];
    logic [3:0] order[4];
    int         n_ord;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = '0; req_name = '0; dwell = 24'd3;
        #2;

        // Reset state
        step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done",  32'(done),  0);
        chk("rst_name",  32'(name),  0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_busy",  32'(busy),  0);
        reset = 1'b0;

        // Single word: requester 1, name 3 (3 digits), dwell 3, gap 2
        for (int i = 0; i < 9; i++) tv[i] = '{4'b0010, 4'b0010, 4'b0000, 5'(i / 3), 1'b0, 1'b1};
        tv[9]  = '{4'b0010, 4'b0000, 4'b0010, 5'd2, 1'b1, 1'b1};
        tv[10] = '{4'b0000, 4'b0000, 4'b0000, 5'd2, 1'b1, 1'b1};
        tv[11] = '{4'b0000, 4'b0000, 4'b0000, 5'd2, 1'b1, 1'b0};
        tv[12] = '{4'b0000, 4'b0000, 4'b0000, 5'd2, 1'b1, 1'b0};
        req_name = {3'd0, 3'd0, 3'd3, 3'd0};
        dwell    = 24'd3;
        for (int i = 0; i < 13; i++) begin
            req = tv[i].req;
            step();
            chk("tv_grant", 32'(grant), 32'(tv[i].g));
            chk("tv_done",  32'(done),  32'(tv[i].d));
            chk("tv_blank", 32'(blank), 32'(tv[i].bl));
            chk("tv_busy",  32'(busy),  32'(tv[i].bz));
            if (!tv[i].bl) begin
                chk("tv_digit", 32'(digit), 32'(tv[i].dig));
                chk("tv_name",  32'(name),  3);
            end
        end

        // All four requesting, each drops after its own done
        do_reset();
        req = 4'b1111; dwell = 24'd1; req_name = {3'd5, 3'd2, 3'd0, 3'd5};
        n_ord = 0;
        for (int c = 0; c < 200 && n_ord < 4; c++) begin
            step();
            if (done != '0) begin
                order[n_ord] = done;
                n_ord++;
                req = req & ~done;
            end
        end
        chk("rr_count", 32'(n_ord), 4);
        for (int i = 0; i < n_ord; i++) chk("rr_order", 32'(order[i]), 32'(1 << i));

        // Owner abandons at digit 1
        do_reset();
        req_name = {3'd0, 3'd0, 3'd3, 3'd0}; dwell = 24'd2; req = 4'b0010;
        step(); step(); step();
        chk("ab_digit", 32'(digit), 1);
        req = '0;
        step();
        chk("ab_grant", 32'(grant), 0);
        chk("ab_done",  32'(done),  0);
        chk("ab_blank", 32'(blank), 1);
        step();
        chk("ab_blank2", 32'(blank), 1);
        chk("ab_done2",  32'(done),  0);
        step();
        chk("ab_idle", 32'(busy), 0);

        // dwell = 1 stepping, then reset at digit 2 (coincides with completion)
        do_reset();
        dwell = 24'd1; req = 4'b0010;
        step(); chk("d1_dig0", 32'(digit), 0);
        step(); chk("d1_dig1", 32'(digit), 1);
        step(); chk("d1_dig2", 32'(digit), 2);
        reset = 1'b1;
        step();
        chk("mr_grant", 32'(grant), 0);
        chk("mr_digit", 32'(digit), 0);
        chk("mr_name",  32'(name),  0);
        chk("mr_blank", 32'(blank), 1);
        chk("mr_busy",  32'(busy),  0);
        chk("mr_done",  32'(done),  0);
        reset = 1'b0; req = '0;
        step();
        chk("mr_nodone", 32'(done), 0);

        // name and dwell changes mid-word are ignored
        do_reset();
        req_name = {3'd0, 3'd0, 3'd3, 3'd0}; dwell = 24'd2; req = 4'b0010;
        step();
        req_name = '1; dwell = 24'd5;
        step(); chk("mw_dig0", 32'(digit), 0);
        step(); chk("mw_dig1", 32'(digit), 1);
        chk("mw_name", 32'(name), 3);
        for (int c = 0; c < 40 && done == '0; c++) step();
        chk("mw_done", 32'(done), 32'(4'b0010));
        req = '0;
        step(); step(); step();

        // dwell = 0 selects the default period
        do_reset();
        dwell = '0; req_name = {3'd0, 3'd0, 3'd0, 3'd1}; req = 4'b0001;
        step();
        for (int k = 0; k < 5; k++) step();
        chk("d0_dig0", 32'(digit), 0);
        step();
        chk("d0_dig1", 32'(digit), 1);
        req = '0;
        step(); step(); step();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < NR; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 3) == 0) req_name = 12'($urandom);
            if ($urandom_range(0, 5) == 0) dwell = 24'($urandom_range(0, 4));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
